// File: rtl/alphabet_ranker_pkg.sv
// Shared types and width helpers for the alphabet ranker.
// State encoding is exported so checkers can bind to the FSM directly.
package alphabet_ranker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    RANK  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/absdiff_unit.sv
// Combinational unsigned absolute difference |A - B|.
// The result fits in DATA_W bits, so there is no wrap.
module absdiff_unit #(
  parameter int DATA_W = 15
) (
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] Y
);

  assign Y = (A >= B) ? (A - B) : (B - A);

endmodule

// File: rtl/alphabet_ranker.sv
// Streaming sum-of-absolute-differences ranker: per-class distance against a
// reference template, with on-the-fly best / second-best tracking.
//
// Handshake: a beat (SENSOR_IN, REF_IN) transfers on a rising CLK edge where
// IN_VALID && IN_READY; IN_READY is high only in ACCUM and does not depend on
// IN_VALID. OUT_VALID is a one-cycle pulse with no back-pressure.
module alphabet_ranker
  import alphabet_ranker_pkg::*;
#(
  parameter  int DATA_W      = 15,
  parameter  int NUM_CLASSES = 64,
  parameter  int NUM_CH      = 5,
  parameter  int MARGIN_TH   = 16,
  localparam int CLS_W       = width_of(NUM_CLASSES),
  localparam int CH_W        = width_of(NUM_CH),
  localparam int ACC_W       = DATA_W + $clog2(NUM_CH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] SENSOR_IN,
  input  logic [DATA_W-1:0] REF_IN,
  output logic              BUSY,
  output logic              OUT_VALID,
  output logic [CLS_W-1:0]  BEST_ADDR,
  output logic [ACC_W-1:0]  BEST_DIST,
  output logic [CLS_W-1:0]  SECOND_ADDR,
  output logic [ACC_W-1:0]  SECOND_DIST,
  output logic              CONFIDENT,
  output state_t            DBG_STATE
);

  state_t state, state_nxt;

  logic [CLS_W-1:0]  cls_cnt;
  logic [CH_W-1:0]   ch_cnt;
  logic [ACC_W-1:0]  acc;
  logic              pend_valid;
  logic [ACC_W-1:0]  pend_dist;
  logic [CLS_W-1:0]  pend_addr;
  logic [CLS_W-1:0]  best_addr, second_addr;
  logic [ACC_W-1:0]  best_dist, second_dist;
  logic              confident;

  logic [DATA_W-1:0] diff;
  logic [ACC_W-1:0]  class_total;
  logic              beat, last_ch, last_cls;

  logic [CLS_W-1:0]  best_addr_nxt, second_addr_nxt;
  logic [ACC_W-1:0]  best_dist_nxt, second_dist_nxt;
  logic              conf_nxt;

  absdiff_unit #(.DATA_W(DATA_W)) u_absdiff (
    .A (SENSOR_IN),
    .B (REF_IN),
    .Y (diff)
  );

  assign beat        = IN_VALID && (state == ACCUM);
  assign last_ch     = (ch_cnt == CH_W'(NUM_CH - 1));
  assign last_cls    = (cls_cnt == CLS_W'(NUM_CLASSES - 1));
  assign class_total = acc + ACC_W'(diff);

  // Top-2 insertion of the pending class; strict < keeps the lower index on ties.
  always_comb begin
    best_addr_nxt   = best_addr;
    best_dist_nxt   = best_dist;
    second_addr_nxt = second_addr;
    second_dist_nxt = second_dist;
    if (pend_valid) begin
      if (pend_dist < best_dist) begin
        second_addr_nxt = best_addr;
        second_dist_nxt = best_dist;
        best_addr_nxt   = pend_addr;
        best_dist_nxt   = pend_dist;
      end else if (pend_dist < second_dist) begin
        second_addr_nxt = pend_addr;
        second_dist_nxt = pend_dist;
      end
    end
    conf_nxt = (second_dist_nxt - best_dist_nxt) >= ACC_W'(MARGIN_TH);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = ACCUM;
      ACCUM:   if (beat && last_ch && last_cls) state_nxt = RANK;
      RANK:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // START from any state (re)opens a frame; mid-frame it aborts silently.
    if (START) state_nxt = ACCUM;
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cls_cnt     <= '0;
      ch_cnt      <= '0;
      acc         <= '0;
      pend_valid  <= 1'b0;
      pend_dist   <= '0;
      pend_addr   <= '0;
      best_addr   <= '0;
      best_dist   <= '0;
      second_addr <= '0;
      second_dist <= '0;
      confident   <= 1'b0;
    end else if (START) begin
      cls_cnt     <= '0;
      ch_cnt      <= '0;
      acc         <= '0;
      pend_valid  <= 1'b0;
      best_addr   <= '0;
      best_dist   <= '1;
      second_addr <= '0;
      second_dist <= '1;
      confident   <= 1'b0;
    end else begin
      pend_valid  <= 1'b0;
      best_addr   <= best_addr_nxt;
      best_dist   <= best_dist_nxt;
      second_addr <= second_addr_nxt;
      second_dist <= second_dist_nxt;
      if (beat) begin
        if (last_ch) begin
          pend_valid <= 1'b1;
          pend_dist  <= class_total;
          pend_addr  <= cls_cnt;
          acc        <= '0;
          ch_cnt     <= '0;
          cls_cnt    <= last_cls ? '0 : cls_cnt + CLS_W'(1);
        end else begin
          acc    <= class_total;
          ch_cnt <= ch_cnt + CH_W'(1);
        end
      end
      // Final insertion lands on the RANK edge, so latch confidence from it.
      if (state == RANK) confident <= conf_nxt;
    end
  end

  assign IN_READY    = (state == ACCUM);
  assign BUSY        = (state == ACCUM) || (state == RANK);
  assign OUT_VALID   = (state == DONE);
  assign BEST_ADDR   = best_addr;
  assign BEST_DIST   = best_dist;
  assign SECOND_ADDR = second_addr;
  assign SECOND_DIST = second_dist;
  assign CONFIDENT   = confident;
  assign DBG_STATE   = state;

endmodule

// File: tb/tb_alphabet_ranker.sv
// Scoreboard bench for alphabet_ranker: a 4-class/2-channel instance and a
// 1-class/2-channel instance sharing the beat inputs, each with its own START.
module tb_alphabet_ranker;
  import alphabet_ranker_pkg::*;

  localparam int DW      = 8;
  localparam int NCH     = 2;
  localparam int ACC_W   = DW + $clog2(NCH + 1);
  localparam int M_CLS_W = 2;
  localparam int S_CLS_W = 1;
  localparam int M_EXP_W = 2 * M_CLS_W + 2 * ACC_W + 1;
  localparam int S_EXP_W = 2 * S_CLS_W + 2 * ACC_W + 1;
  localparam logic [ACC_W-1:0] ALL_ONES = '1;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          m_start, s_start, in_valid;
  logic [DW-1:0] sensor, ref_in;

  logic               m_in_ready, m_busy, m_out_valid, m_confident;
  logic [M_CLS_W-1:0] m_best_addr, m_second_addr;
  logic [ACC_W-1:0]   m_best_dist, m_second_dist;
  state_t             m_state;

  logic               s_in_ready, s_busy, s_out_valid, s_confident;
  logic [S_CLS_W-1:0] s_best_addr, s_second_addr;
  logic [ACC_W-1:0]   s_best_dist, s_second_dist;
  state_t             s_state;

  alphabet_ranker #(.DATA_W(DW), .NUM_CLASSES(4), .NUM_CH(NCH), .MARGIN_TH(16)) u_dut (
    .CLK(clk), .RST(rst), .START(m_start), .IN_VALID(in_valid), .IN_READY(m_in_ready),
    .SENSOR_IN(sensor), .REF_IN(ref_in), .BUSY(m_busy), .OUT_VALID(m_out_valid),
    .BEST_ADDR(m_best_addr), .BEST_DIST(m_best_dist), .SECOND_ADDR(m_second_addr),
    .SECOND_DIST(m_second_dist), .CONFIDENT(m_confident), .DBG_STATE(m_state)
  );

  alphabet_ranker #(.DATA_W(DW), .NUM_CLASSES(1), .NUM_CH(NCH), .MARGIN_TH(16)) u_one (
    .CLK(clk), .RST(rst), .START(s_start), .IN_VALID(in_valid), .IN_READY(s_in_ready),
    .SENSOR_IN(sensor), .REF_IN(ref_in), .BUSY(s_busy), .OUT_VALID(s_out_valid),
    .BEST_ADDR(s_best_addr), .BEST_DIST(s_best_dist), .SECOND_ADDR(s_second_addr),
    .SECOND_DIST(s_second_dist), .CONFIDENT(s_confident), .DBG_STATE(s_state)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  int m_last_acc = 0;
  int s_last_acc = 0;
  logic [M_EXP_W-1:0] m_exp_q[$];
  logic [S_EXP_W-1:0] s_exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [M_EXP_W-1:0] pack_m(input int ba, input int bd, input int sa,
                                                  input int sd, input bit c);
    return {M_CLS_W'(ba), ACC_W'(bd), M_CLS_W'(sa), ACC_W'(sd), c};
  endfunction

  // monitors: pop on every OUT_VALID pulse, also check 2-cycle latency
  always @(negedge clk) begin
    if (m_out_valid) begin
      if (m_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m_unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        check("m_result", 32'({m_best_addr, m_best_dist, m_second_addr, m_second_dist,
                               m_confident}), 32'(m_exp_q.pop_front()));
        check("m_latency", cyc - m_last_acc, 2);
      end
    end
  end

  always @(negedge clk) begin
    if (s_out_valid) begin
      if (s_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL s_unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        check("s_result", 32'({s_best_addr, s_best_dist, s_second_addr, s_second_dist,
                               s_confident}), 32'(s_exp_q.pop_front()));
        check("s_latency", cyc - s_last_acc, 2);
      end
    end
  end

  // drivers
  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) s_start = 1'b1;
    else     m_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    m_start = 1'b0;
  endtask

  task automatic send_beat(input bit sel, input logic [DW-1:0] s, input logic [DW-1:0] r,
                           input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    sensor   = s;
    ref_in   = r;
    check("ready_in_frame", sel ? s_in_ready : m_in_ready, 1);
    if (sel) s_last_acc = cyc;
    else     m_last_acc = cyc;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Class total t is split as |0 - h| + |(t-h+3) - 3| with h = t/2.
  task automatic run_frame4(input int t0, input int t1, input int t2, input int t3,
                            input bit gaps);
    int tot[4];
    tot = '{t0, t1, t2, t3};
    pulse_start(1'b0);
    check("m_busy_in_frame", m_busy, 1);
    for (int k = 0; k < 4; k++) begin
      int h;
      h = tot[k] / 2;
      send_beat(1'b0, 8'd0, DW'(h), gaps ? int'($urandom_range(0, 3)) : 0);
      send_beat(1'b0, DW'(tot[k] - h + 3), 8'd3, gaps ? int'($urandom_range(0, 3)) : 0);
    end
  endtask

  task automatic wait_drain(input bit sel);
    int t;
    t = 0;
    while (((sel ? s_exp_q.size() : m_exp_q.size()) != 0) && t < 20) begin
      @(negedge clk);
      t++;
    end
    check(sel ? "s_drain" : "m_drain", sel ? s_exp_q.size() : m_exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    m_start  = 1'b0;
    s_start  = 1'b0;
    in_valid = 1'b0;
    sensor   = '0;
    ref_in   = '0;
    repeat (3) @(negedge clk);
    check("rst_m_ctrl", {m_in_ready, m_busy, m_out_valid, m_confident}, 0);
    check("rst_m_top2", {m_best_addr, m_best_dist, m_second_addr, m_second_dist}, 0);
    check("rst_s_ctrl", {s_in_ready, s_busy, s_out_valid, s_confident}, 0);
    rst = 1'b0;

    // totals 30,12,50,20: best 1/12, second 3/20, margin 8
    m_exp_q.push_back(pack_m(1, 12, 3, 20, 0));
    run_frame4(30, 12, 50, 20, 1'b0);
    wait_drain(1'b0);
    repeat (3) @(negedge clk);
    check("m_hold", 32'({m_best_addr, m_best_dist, m_second_addr, m_second_dist, m_confident}),
          32'(pack_m(1, 12, 3, 20, 0)));
    check("m_idle_after_done", {m_busy, m_in_ready}, 0);

    // tie on 40: lower index wins, margin 0
    m_exp_q.push_back(pack_m(0, 40, 1, 40, 0));
    run_frame4(40, 40, 90, 200, 1'b0);
    wait_drain(1'b0);

    // margin exactly 16
    m_exp_q.push_back(pack_m(1, 34, 0, 50, 1));
    run_frame4(50, 34, 100, 200, 1'b0);
    wait_drain(1'b0);

    // late best with large margin
    m_exp_q.push_back(pack_m(2, 5, 1, 60, 1));
    run_frame4(100, 60, 5, 80, 1'b0);
    wait_drain(1'b0);

    // first frame again, with random IN_VALID gaps
    m_exp_q.push_back(pack_m(1, 12, 3, 20, 0));
    run_frame4(30, 12, 50, 20, 1'b1);
    wait_drain(1'b0);

    // abort after 3 beats, then a full frame
    pulse_start(1'b0);
    send_beat(1'b0, 8'd0, 8'd100, 0);
    send_beat(1'b0, 8'd100, 8'd0, 0);
    send_beat(1'b0, 8'd50, 8'd0, 0);
    m_exp_q.push_back(pack_m(2, 5, 1, 60, 1));
    run_frame4(100, 60, 5, 80, 1'b0);
    wait_drain(1'b0);

    // single class: 15 + 15 = 30, second stays all-ones
    s_exp_q.push_back({S_CLS_W'(0), ACC_W'(30), S_CLS_W'(0), ALL_ONES, 1'b1});
    pulse_start(1'b1);
    send_beat(1'b1, 8'd10, 8'd25, 0);
    send_beat(1'b1, 8'd25, 8'd10, 0);
    wait_drain(1'b1);

    // reset mid-ACCUM
    pulse_start(1'b0);
    send_beat(1'b0, 8'd0, 8'd7, 0);
    send_beat(1'b0, 8'd9, 8'd0, 0);
    send_beat(1'b0, 8'd0, 8'd11, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ctrl", {m_in_ready, m_busy, m_out_valid, m_confident}, 0);
    check("midrst_top2", {m_best_addr, m_best_dist, m_second_addr, m_second_dist}, 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("midrst_stays_idle", {m_in_ready, m_busy}, 0);
    m_exp_q.push_back(pack_m(0, 40, 1, 40, 0));
    run_frame4(40, 40, 90, 200, 1'b0);
    wait_drain(1'b0);

    check("final_queues", m_exp_q.size() + s_exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
